lcd_cmd_issuer: RTL and testbench

- Command front end that sits directly upstream of LCD_CTRL and drives its cmd/cmd_valid inputs.
- Buffers 3-bit image commands pushed by a host (or bench sequencer) in a FIFO.
- Issues them one at a time, obeying LCD_CTRL's busy handshake.
- After a write command (0), stalls until LCD_CTRL signals done, then resumes. Keeps issue and frame counters for debug.

---
 rtl/lcd_cmd_issuer_if.sv | 18 +
 rtl/lcd_cmd_issuer.sv | 120 ++++++++++++
 tb/tb_lcd_cmd_issuer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_issuer_if.sv
// Host push channel for lcd_cmd_issuer: a 3-bit image command with a valid/ready handshake.
interface lcd_cmd_issuer_if;
    logic [2:0] host_cmd;
    logic       host_valid;
    logic       host_ready;

    modport master (
        output host_cmd,
        output host_valid,
        input  host_ready
    );

    modport slave (
        input  host_cmd,
        input  host_valid,
        output host_ready
    );
endinterface

// File: rtl/lcd_cmd_issuer.sv
// Buffers host image commands and issues them to LCD_CTRL one at a time, honouring its busy
// handshake and stalling after a write until LCD_CTRL reports done.
module lcd_cmd_issuer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    lcd_cmd_issuer_if.slave          host,
    input  logic                     busy,
    input  logic                     done,
    output logic [2:0]               cmd,
    output logic                     cmd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         issued_cnt,
    output logic [CNT_W-1:0]         frame_cnt,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StGuard,
        StWait,
        StWaitDone
    } state_e;

    state_e        state_q;
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          done_q;

    logic push;
    logic pop;
    logic done_rise;

    assign host.host_ready = (level != LW'(DEPTH)) && !reset;
    assign push            = host.host_valid && host.host_ready;
    // Pop only on the IDLE->ISSUE edge; level is registered so an empty FIFO is never popped.
    assign pop             = (state_q == StIdle) && (level != '0) && !busy;
    assign done_rise       = done && !done_q;

    // Storage needs no reset: push is held off while reset is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host.host_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level      <= '0;
            done_q     <= 1'b0;
            cmd        <= 3'd0;
            cmd_valid  <= 1'b0;
            issued_cnt <= '0;
            frame_cnt  <= '0;
            overflow   <= 1'b0;
        end else begin
            done_q <= done;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (host.host_valid && !host.host_ready) begin
                overflow <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (pop) begin
                        cmd        <= mem_q[rd_ptr_q];
                        cmd_valid  <= 1'b1;
                        issued_cnt <= issued_cnt + CNT_W'(1);
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    cmd_valid <= 1'b0;
                    state_q   <= StGuard;
                end
                // LCD_CTRL raises busy a cycle late, so busy is not trusted here.
                StGuard: begin
                    state_q <= (cmd == 3'd0) ? StWaitDone : StWait;
                end
                StWait: begin
                    if (!busy) begin
                        state_q <= StIdle;
                    end
                end
                StWaitDone: begin
                    if (done_rise) begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        state_q   <= StWait;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed bench for lcd_cmd_issuer: issue latency, FIFO full/overflow, busy and done
// handshakes, mid-run reset and counter wrap, with hand-computed expectations.
module tb_lcd_cmd_issuer;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy_tb;
    logic       busy_model = 1'b0;
    logic       busy_mode;
    logic       busy;
    logic       done;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [3:0] level;
    logic [7:0] issued_cnt;
    logic [7:0] frame_cnt;
    logic       overflow;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int cv_double = 0;
    int busy_cnt = 0;
    logic cv_last = 1'b0;
    logic cv_prev = 1'b0;

    logic [2:0] log_cmd[$];
    int         log_cyc[$];

    lcd_cmd_issuer_if host_bus ();

    lcd_cmd_issuer #(
        .DEPTH(8),
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (host_bus),
        .busy      (busy),
        .done      (done),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .level     (level),
        .issued_cnt(issued_cnt),
        .frame_cnt (frame_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    assign busy = busy_mode ? busy_model : busy_tb;

    always @(posedge clk) cyc <= cyc + 1;

    // Issue log plus a check that cmd_valid never stays high two cycles running.
    always @(negedge clk) begin
        if (cmd_valid) begin
            log_cmd.push_back(cmd);
            log_cyc.push_back(cyc);
            if (cv_last) cv_double++;
        end
        cv_last = cmd_valid;
        cv_prev = cmd_valid;
    end

    // LCD_CTRL stand-in: busy high for 5 cycles starting the cycle after each cmd_valid.
    always @(posedge clk) begin
        #1;
        if (busy_cnt != 0) busy_cnt--;
        if (cv_prev) busy_cnt = 5;
        busy_model = (busy_cnt != 0);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"},      32'(cmd), 0);
        check({tag, "_cv"},       32'(cmd_valid), 0);
        check({tag, "_level"},    32'(level), 0);
        check({tag, "_issued"},   32'(issued_cnt), 0);
        check({tag, "_frame"},    32'(frame_cnt), 0);
        check({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    logic [2:0] seq3 [3];
    int base;
    int n;

    initial begin
        seq3 = '{3'd1, 3'd2, 3'd5};
        reset = 1'b1;
        busy_tb = 1'b0;
        busy_mode = 1'b0;
        done = 1'b0;
        host_bus.host_valid = 1'b0;
        host_bus.host_cmd = 3'd0;
        tick();
        tick();
        check("rst_ready", 32'(host_bus.host_ready), 0);
        check_reset_vals("rst");
        reset = 1'b0;
        tick();
        check("ready_after_rst", 32'(host_bus.host_ready), 1);

        // Single command: cmd_valid one cycle after the push edge.
        host_bus.host_cmd = 3'd3;
        host_bus.host_valid = 1'b1;
        tick();
        host_bus.host_valid = 1'b0;
        check("t1_level_after_push", 32'(level), 1);
        check("t1_cv_early", 32'(cmd_valid), 0);
        tick();
        check("t1_cv", 32'(cmd_valid), 1);
        check("t1_cmd", 32'(cmd), 3);
        check("t1_issued", 32'(issued_cnt), 1);
        check("t1_level", 32'(level), 0);
        tick();
        check("t1_cv_drop", 32'(cmd_valid), 0);
        repeat (6) tick();

        // Fill under busy: eight accepted, ninth dropped.
        busy_tb = 1'b1;
        tick();
        base = log_cmd.size();
        for (int i = 0; i < 9; i++) begin
            host_bus.host_cmd = 3'(7 - (i % 7));
            host_bus.host_valid = 1'b1;
            tick();
            if (i == 7) check("t2_full_ready", 32'(host_bus.host_ready), 0);
        end
        host_bus.host_valid = 1'b0;
        check("t2_level", 32'(level), 8);
        check("t2_overflow", 32'(overflow), 1);
        check("t2_no_issue", 32'(log_cmd.size() - base), 0);
        busy_tb = 1'b0;
        repeat (45) tick();
        check("t2_count", 32'(log_cmd.size() - base), 8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < log_cmd.size()) begin
                check("t2_order", 32'(log_cmd[base + k]), 32'(7 - (k % 7)));
                if (k > 0) check("t2_gap", 32'(log_cyc[base + k] - log_cyc[base + k - 1]), 4);
            end
        end
        check("t2_issued", 32'(issued_cnt), 9);
        check("t2_level_end", 32'(level), 0);

        // Busy handshake: each issue waits for busy to fall (5 busy cycles -> 8 apart).
        busy_mode = 1'b1;
        base = log_cmd.size();
        for (int i = 0; i < 3; i++) begin
            host_bus.host_cmd = seq3[i];
            host_bus.host_valid = 1'b1;
            tick();
        end
        host_bus.host_valid = 1'b0;
        repeat (40) tick();
        check("t3_count", 32'(log_cmd.size() - base), 3);
        for (int k = 0; k < 3; k++) begin
            if (base + k < log_cmd.size()) begin
                check("t3_order", 32'(log_cmd[base + k]), 32'(seq3[k]));
                if (k > 0) check("t3_gap", 32'(log_cyc[base + k] - log_cyc[base + k - 1]), 8);
            end
        end
        busy_mode = 1'b0;
        repeat (4) tick();

        // done outside WAIT_DONE is ignored.
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        tick();
        check("t4_idle_done", 32'(frame_cnt), 0);

        // Write stalls the queue until done rises.
        base = log_cmd.size();
        host_bus.host_cmd = 3'd0;
        host_bus.host_valid = 1'b1;
        tick();
        host_bus.host_cmd = 3'd6;
        tick();
        host_bus.host_valid = 1'b0;
        check("t4_wr_cv", 32'(cmd_valid), 1);
        check("t4_wr_cmd", 32'(cmd), 0);
        repeat (10) tick();
        check("t4_stalled", 32'(log_cmd.size() - base), 1);
        check("t4_level", 32'(level), 1);
        check("t4_frame0", 32'(frame_cnt), 0);
        done = 1'b1;
        tick();
        check("t4_frame1", 32'(frame_cnt), 1);
        check("t4_cv_rise", 32'(cmd_valid), 0);
        tick();
        check("t4_cv_rise1", 32'(cmd_valid), 0);
        tick();
        check("t4_cv6", 32'(cmd_valid), 1);
        check("t4_cmd6", 32'(cmd), 6);
        done = 1'b0;
        repeat (6) tick();

        // Reset while in WAIT with three queued; pushes during reset are ignored.
        host_bus.host_cmd = 3'd5;
        host_bus.host_valid = 1'b1;
        tick();
        host_bus.host_valid = 1'b0;
        tick();
        busy_tb = 1'b1;
        host_bus.host_cmd = 3'd4;
        host_bus.host_valid = 1'b1;
        repeat (3) tick();
        host_bus.host_valid = 1'b0;
        check("t5_level_q", 32'(level), 3);
        reset = 1'b1;
        host_bus.host_cmd = 3'd2;
        host_bus.host_valid = 1'b1;
        tick();
        check_reset_vals("t5");
        check("t5_ready_rst", 32'(host_bus.host_ready), 0);
        host_bus.host_valid = 1'b0;
        reset = 1'b0;
        busy_tb = 1'b0;
        base = log_cmd.size();
        repeat (10) tick();
        check("t5_no_issue", 32'(log_cmd.size() - base), 0);
        check("t5_level_after", 32'(level), 0);
        check("t5_overflow_after", 32'(overflow), 0);

        // 256 issues wrap issued_cnt to zero without overflow.
        base = log_cmd.size();
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!host_bus.host_ready && n < 50) begin
                tick();
                n++;
            end
            if (n == 50) check("t6_push_timeout", 32'(n), 0);
            host_bus.host_cmd = 3'(1 + (i % 7));
            host_bus.host_valid = 1'b1;
            tick();
            host_bus.host_valid = 1'b0;
        end
        n = 0;
        while (level != 0 && n < 200) begin
            tick();
            n++;
        end
        if (n == 200) check("t6_drain_timeout", 32'(n), 0);
        repeat (10) tick();
        check("t6_issued_wrap", 32'(issued_cnt), 0);
        check("t6_overflow", 32'(overflow), 0);
        check("t6_count", 32'(log_cmd.size() - base), 256);
        for (int k = 0; k < 256; k++) begin
            if (base + k < log_cmd.size()) begin
                check("t6_order", 32'(log_cmd[base + k]), 32'(1 + (k % 7)));
            end
        end
        check("cv_single_cycle", 32'(cv_double), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
